// File: rtl/dmem_responder_pkg.sv
// Shared defaults, FSM state encoding and counter width for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DMEM_DATA_W = 32;
    localparam int unsigned DMEM_ADDR_W = 10;
    localparam int unsigned DMEM_DEPTH  = 1024;
    localparam int unsigned DMEM_CNT_W  = 4;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_BUSY = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder: synchronous write, combinational read port.
// The read value is captured into the responder's response register, so the
// storage-to-core read path is registered.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W = DMEM_DATA_W,
    parameter int unsigned ADDR_W = DMEM_ADDR_W,
    parameter int unsigned DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] memory [0:DEPTH-1];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            memory[addr] <= wdata;
        end
    end

    assign rdata_c = memory[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_STATES
// cycles, performs the access and returns a valid/ready response.
// Optional feature: define DMEM_PARITY_EN to store and check an even-parity bit per word.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = DMEM_DATA_W,
    parameter int unsigned ADDR_W      = DMEM_ADDR_W,
    parameter int unsigned DEPTH       = DMEM_DEPTH,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

`ifdef DMEM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif
    localparam int unsigned CMP_W = ADDR_W + 1;

    dmem_state_e           state, state_n;
    logic [DMEM_CNT_W-1:0] cnt, cnt_n;
    logic                  lat_we, lat_we_n;
    logic [ADDR_W-1:0]     lat_addr, lat_addr_n;
    logic [DATA_W-1:0]     lat_wdata, lat_wdata_n;
    logic                  req_ready_n, rsp_valid_n, rsp_err_n;
    logic [DATA_W-1:0]     rsp_rdata_n;

    logic                  mem_we_c;
    logic [MEM_W-1:0]      mem_wdata_c, mem_rdata_c;
    logic                  in_range_c, par_err_c;

    dmem_array #(
        .DATA_W (MEM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) array0 (
        .clk     (clk),
        .we      (mem_we_c),
        .addr    (lat_addr),
        .wdata   (mem_wdata_c),
        .rdata_c (mem_rdata_c)
    );

    assign in_range_c = CMP_W'(lat_addr) < CMP_W'(DEPTH);

    // Parity generation on store and check on load (overall even parity incl. the parity bit).
`ifdef DMEM_PARITY_EN
    assign mem_wdata_c = {^lat_wdata, lat_wdata};
    assign par_err_c   = ^mem_rdata_c;
`else
    assign mem_wdata_c = lat_wdata;
    assign par_err_c   = 1'b0;
`endif

    // State and registered outputs; a reset drops any pending request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= DMEM_IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            lat_we    <= lat_we_n;
            lat_addr  <= lat_addr_n;
            lat_wdata <= lat_wdata_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_rdata <= rsp_rdata_n;
            rsp_err   <= rsp_err_n;
        end
    end

    // Next state, wait counter, access and response values.
    // The first RESP cycle (rsp_valid still low) performs the access; later
    // RESP cycles hold the response until the core takes it.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        lat_we_n    = lat_we;
        lat_addr_n  = lat_addr;
        lat_wdata_n = lat_wdata;
        req_ready_n = req_ready;
        rsp_valid_n = rsp_valid;
        rsp_rdata_n = rsp_rdata;
        rsp_err_n   = rsp_err;
        mem_we_c    = 1'b0;

        case (state)
            DMEM_IDLE: begin
                req_ready_n = 1'b1;
                if (req_valid && req_ready) begin
                    lat_we_n    = req_we;
                    lat_addr_n  = req_addr;
                    lat_wdata_n = req_wdata;
                    cnt_n       = DMEM_CNT_W'(WAIT_STATES);
                    req_ready_n = 1'b0;
                    state_n     = (WAIT_STATES != 0) ? DMEM_BUSY : DMEM_RESP;
                end
            end
            DMEM_BUSY: begin
                cnt_n = cnt - DMEM_CNT_W'(1);
                if (cnt == DMEM_CNT_W'(1)) begin
                    state_n = DMEM_RESP;
                end
            end
            DMEM_RESP: begin
                if (!rsp_valid) begin
                    rsp_valid_n = 1'b1;
                    if (!in_range_c) begin
                        rsp_rdata_n = '0;
                        rsp_err_n   = 1'b1;
                    end else if (lat_we) begin
                        mem_we_c    = 1'b1;
                        rsp_rdata_n = '0;
                        rsp_err_n   = 1'b0;
                    end else begin
                        rsp_rdata_n = mem_rdata_c[DATA_W-1:0];
                        rsp_err_n   = par_err_c;
                    end
                end else if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                    state_n     = DMEM_IDLE;
                end
            end
            default: begin
                state_n = DMEM_IDLE;
            end
        endcase
    end

endmodule
